// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge: directory entry layout,
// transaction-manager states and the 4KB boundary helper.
package apb2axi_pkg;

  localparam int AXI_ADDR_W    = 32;
  localparam int AXI_DATA_W    = 32;
  localparam int TAG_W         = 4;
  localparam int AXI_4KB_SHIFT = 12;

  // Largest legal AxSIZE: one beat may not exceed the data bus width.
  localparam logic [2:0] AXI_MAX_SIZE = 3'($clog2(AXI_DATA_W / 8));

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  is_write;
  } directory_entry_t;

  typedef enum logic [1:0] {
    TXN_IDLE,
    TXN_ISSUE,
    TXN_DROP
  } txn_state_e;

  // True when the burst's last byte lands in a different 4KB page than its first.
  function automatic logic crosses_4kb(input logic [AXI_ADDR_W-1:0] addr,
                                       input logic [7:0]            len,
                                       input logic [2:0]            size);
    logic [AXI_ADDR_W:0] bytes;
    logic [AXI_ADDR_W:0] end_addr;
    bytes    = ((AXI_ADDR_W+1)'(len) + (AXI_ADDR_W+1)'(1)) << size;
    end_addr = {1'b0, addr} + bytes - (AXI_ADDR_W+1)'(1);
    return addr[AXI_ADDR_W-1:AXI_4KB_SHIFT] != end_addr[AXI_ADDR_W-1:AXI_4KB_SHIFT];
  endfunction

endpackage

// File: rtl/apb2axi_credit_cnt.sv
// Up/down outstanding-transaction counter with credit-available compare and a
// sticky underflow flag.
module apb2axi_credit_cnt #(
  parameter int MAX_P   = 4,
  parameter int CNT_W_P = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               dec,
  output logic [CNT_W_P-1:0] count,
  output logic               avail,
  output logic               underflow
);

  logic [CNT_W_P-1:0] cnt_q, cnt_d;
  logic               uf_q, uf_d;

  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q == '0) uf_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  assign count     = cnt_q;
  assign avail     = cnt_q < CNT_W_P'(MAX_P);
  assign underflow = uf_q;

endmodule

// File: rtl/apb2axi_txn_mgr.sv
// Pops PENDING directory entries one at a time and issues them on AR or AW,
// gated by per-direction credits; illegal entries are dropped with a report.
module apb2axi_txn_mgr
  import apb2axi_pkg::*;
#(
  parameter int TAG_W_P           = TAG_W,
  parameter int MAX_OUTSTANDING_P = 4,
  parameter int CNT_W_P           = 4
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  pending_valid,
  input  directory_entry_t      pending_entry,
  input  logic [TAG_W_P-1:0]    pending_tag,
  output logic                  pending_pop,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [TAG_W_P-1:0]    ar_id,
  output logic [AXI_ADDR_W-1:0] ar_addr,
  output logic [7:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [TAG_W_P-1:0]    aw_id,
  output logic [AXI_ADDR_W-1:0] aw_addr,
  output logic [7:0]            aw_len,
  output logic [2:0]            aw_size,
  output logic [1:0]            aw_burst,
  input  logic                  cpl_valid,
  input  logic                  cpl_is_write,
  output logic                  drop_valid,
  output logic [TAG_W_P-1:0]    drop_tag,
  output logic [CNT_W_P-1:0]    rd_outstanding,
  output logic [CNT_W_P-1:0]    wr_outstanding,
  output logic                  underflow_err
);

  txn_state_e         state_q, state_d;
  directory_entry_t   hold_q, hold_d;
  logic [TAG_W_P-1:0] tag_q, tag_d;
  logic               ar_valid_q, ar_valid_d;
  logic               aw_valid_q, aw_valid_d;
  logic               drop_valid_q, drop_valid_d;
  logic               rd_inc, wr_inc, rd_avail, wr_avail, rd_uf, wr_uf;
  logic               credit_ok, illegal;

  apb2axi_credit_cnt #(.MAX_P(MAX_OUTSTANDING_P), .CNT_W_P(CNT_W_P)) u_rd_cnt (
    .clk(pclk), .rst_n(presetn), .inc(rd_inc), .dec(cpl_valid && !cpl_is_write),
    .count(rd_outstanding), .avail(rd_avail), .underflow(rd_uf)
  );

  apb2axi_credit_cnt #(.MAX_P(MAX_OUTSTANDING_P), .CNT_W_P(CNT_W_P)) u_wr_cnt (
    .clk(pclk), .rst_n(presetn), .inc(wr_inc), .dec(cpl_valid && cpl_is_write),
    .count(wr_outstanding), .avail(wr_avail), .underflow(wr_uf)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    tag_d        = tag_q;
    ar_valid_d   = ar_valid_q;
    aw_valid_d   = aw_valid_q;
    drop_valid_d = 1'b0;
    pending_pop  = 1'b0;
    rd_inc       = 1'b0;
    wr_inc       = 1'b0;
    credit_ok    = pending_entry.is_write ? wr_avail : rd_avail;
    illegal      = crosses_4kb(pending_entry.addr, pending_entry.len, pending_entry.size) ||
                   (pending_entry.size > AXI_MAX_SIZE);
    case (state_q)
      TXN_IDLE: begin
        if (pending_valid && credit_ok) begin
          pending_pop = 1'b1;
          hold_d      = pending_entry;
          tag_d       = pending_tag;
          if (illegal) begin
            state_d      = TXN_DROP;
            drop_valid_d = 1'b1;
          end else begin
            state_d    = TXN_ISSUE;
            ar_valid_d = !pending_entry.is_write;
            aw_valid_d = pending_entry.is_write;
          end
        end
      end
      TXN_ISSUE: begin
        if (ar_valid_q && ar_ready) begin
          ar_valid_d = 1'b0;
          rd_inc     = 1'b1;
          state_d    = TXN_IDLE;
        end
        if (aw_valid_q && aw_ready) begin
          aw_valid_d = 1'b0;
          wr_inc     = 1'b1;
          state_d    = TXN_IDLE;
        end
      end
      TXN_DROP: state_d = TXN_IDLE;
      default:  state_d = TXN_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= TXN_IDLE;
      hold_q       <= '0;
      tag_q        <= '0;
      ar_valid_q   <= 1'b0;
      aw_valid_q   <= 1'b0;
      drop_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      tag_q        <= tag_d;
      ar_valid_q   <= ar_valid_d;
      aw_valid_q   <= aw_valid_d;
      drop_valid_q <= drop_valid_d;
    end
  end

  // Both channels present the same holding register; only one valid is ever high.
  assign ar_valid      = ar_valid_q;
  assign ar_id         = tag_q;
  assign ar_addr       = hold_q.addr;
  assign ar_len        = hold_q.len;
  assign ar_size       = hold_q.size;
  assign ar_burst      = hold_q.burst;
  assign aw_valid      = aw_valid_q;
  assign aw_id         = tag_q;
  assign aw_addr       = hold_q.addr;
  assign aw_len        = hold_q.len;
  assign aw_size       = hold_q.size;
  assign aw_burst      = hold_q.burst;
  assign drop_valid    = drop_valid_q;
  assign drop_tag      = tag_q;
  assign underflow_err = rd_uf || wr_uf;

endmodule

// File: tb/tb_apb2axi_txn_mgr.sv
// Bench for apb2axi_txn_mgr: directed scenarios plus random traffic checked
// against a transaction-level model of the directory, credits and issue rules.
module tb_apb2axi_txn_mgr;
  import apb2axi_pkg::*;

  localparam int MAX = 4;

  typedef struct {
    directory_entry_t e;
    logic [TAG_W-1:0] tag;
  } dir_item_t;

  logic                  pclk, presetn;
  logic                  pending_valid, pending_pop;
  directory_entry_t      pending_entry;
  logic [TAG_W-1:0]      pending_tag;
  logic                  ar_valid, ar_ready, aw_valid, aw_ready;
  logic [TAG_W-1:0]      ar_id, aw_id, drop_tag;
  logic [AXI_ADDR_W-1:0] ar_addr, aw_addr;
  logic [7:0]            ar_len, aw_len;
  logic [2:0]            ar_size, aw_size;
  logic [1:0]            ar_burst, aw_burst;
  logic                  cpl_valid, cpl_is_write, drop_valid, underflow_err;
  logic [3:0]            rd_outstanding, wr_outstanding;

  apb2axi_txn_mgr #(.TAG_W_P(TAG_W), .MAX_OUTSTANDING_P(MAX), .CNT_W_P(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .pending_valid(pending_valid), .pending_entry(pending_entry),
    .pending_tag(pending_tag), .pending_pop(pending_pop),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .cpl_valid(cpl_valid), .cpl_is_write(cpl_is_write),
    .drop_valid(drop_valid), .drop_tag(drop_tag),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .underflow_err(underflow_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: directory contents, the one entry being handled, and credit counts.
  dir_item_t   dir_q[$];
  dir_item_t   cur;
  int          kind;      // 0 idle, 1 read issue, 2 write issue, 3 drop
  int unsigned m_rd, m_wr;
  bit          m_uf;
  int unsigned ar_rdy_pct, aw_rdy_pct, cpl_pct;
  bit          manual_cpl;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit model_illegal(input directory_entry_t e);
    logic [63:0] bytes;
    bytes = (64'(e.len) + 64'd1) << e.size;
    return (64'(e.addr[11:0]) + bytes > 64'd4096) || ((64'd1 << e.size) > 64'(AXI_DATA_W / 8));
  endfunction

  function automatic directory_entry_t mk(input logic [31:0] a, input logic [7:0] l,
                                          input logic [2:0] s, input logic w);
    directory_entry_t e;
    e.addr = a; e.len = l; e.size = s; e.burst = 2'd1; e.is_write = w;
    return e;
  endfunction

  task automatic push(input directory_entry_t e, input logic [TAG_W-1:0] t);
    dir_item_t it;
    it.e = e; it.tag = t;
    dir_q.push_back(it);
  endtask

  // One clock cycle, called and returning at a falling edge.
  task automatic tick();
    bit credit, exp_pop, hs_ar, hs_aw, rd_dec, wr_dec;
    check("ar_valid", ar_valid, kind == 1);
    check("aw_valid", aw_valid, kind == 2);
    check("drop_valid", drop_valid, kind == 3);
    if (kind == 1) begin
      check("ar_id", ar_id, cur.tag);       check("ar_addr", ar_addr, cur.e.addr);
      check("ar_len", ar_len, cur.e.len);   check("ar_size", ar_size, cur.e.size);
      check("ar_burst", ar_burst, cur.e.burst);
    end
    if (kind == 2) begin
      check("aw_id", aw_id, cur.tag);       check("aw_addr", aw_addr, cur.e.addr);
      check("aw_len", aw_len, cur.e.len);   check("aw_size", aw_size, cur.e.size);
      check("aw_burst", aw_burst, cur.e.burst);
    end
    if (kind == 3) check("drop_tag", drop_tag, cur.tag);
    check("rd_outstanding", rd_outstanding, m_rd);
    check("wr_outstanding", wr_outstanding, m_wr);
    check("underflow_err", underflow_err, m_uf);

    ar_ready = ($urandom_range(99) < ar_rdy_pct);
    aw_ready = ($urandom_range(99) < aw_rdy_pct);
    if (!manual_cpl) begin
      cpl_is_write = 1'($urandom_range(1));
      cpl_valid    = ($urandom_range(99) < cpl_pct) && (cpl_is_write ? m_wr > 0 : m_rd > 0);
    end
    pending_valid = dir_q.size() > 0;
    pending_entry = pending_valid ? dir_q[0].e : '0;
    pending_tag   = pending_valid ? dir_q[0].tag : '0;
    #1;
    credit  = pending_valid && (dir_q[0].e.is_write ? m_wr < MAX : m_rd < MAX);
    exp_pop = (kind == 0) && credit;
    check("pending_pop", pending_pop, exp_pop);

    hs_ar  = (kind == 1) && ar_ready;
    hs_aw  = (kind == 2) && aw_ready;
    rd_dec = cpl_valid && !cpl_is_write;
    wr_dec = cpl_valid && cpl_is_write;
    if (hs_ar && !rd_dec) m_rd++;
    else if (rd_dec && !hs_ar) begin
      if (m_rd == 0) m_uf = 1'b1; else m_rd--;
    end
    if (hs_aw && !wr_dec) m_wr++;
    else if (wr_dec && !hs_aw) begin
      if (m_wr == 0) m_uf = 1'b1; else m_wr--;
    end
    if (hs_ar || hs_aw || kind == 3) kind = 0;
    if (exp_pop) begin
      cur  = dir_q.pop_front();
      kind = model_illegal(cur.e) ? 3 : (cur.e.is_write ? 2 : 1);
    end
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic cpl_pulse(input bit is_wr);
    cpl_valid = 1'b1; cpl_is_write = is_wr;
    tick();
    cpl_valid = 1'b0;
  endtask

  initial begin
    presetn = 1'b0; pending_valid = 1'b0; pending_entry = '0; pending_tag = '0;
    ar_ready = 1'b0; aw_ready = 1'b0; cpl_valid = 1'b0; cpl_is_write = 1'b0;
    kind = 0; m_rd = 0; m_wr = 0; m_uf = 1'b0;
    ar_rdy_pct = 100; aw_rdy_pct = 100; cpl_pct = 0; manual_cpl = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst_ar_valid", ar_valid, 0);   check("rst_aw_valid", aw_valid, 0);
    check("rst_drop", drop_valid, 0);     check("rst_pop", pending_pop, 0);
    check("rst_rd_cnt", rd_outstanding, 0);
    check("rst_wr_cnt", wr_outstanding, 0);
    check("rst_uf", underflow_err, 0);
    check("rst_ar_addr", ar_addr, 0);
    presetn = 1'b1;

    // Read pop: pop, issue next cycle, counter visible one cycle after handshake.
    push(mk(32'h1000, 8'd3, 3'd2, 1'b0), 4'd5);
    tick(); tick(); tick();
    check("rd_cnt_t2", rd_outstanding, 1);

    // Write backpressure with a second write waiting behind it.
    aw_rdy_pct = 0;
    push(mk(32'h2000, 8'd0, 3'd2, 1'b1), 4'd2);
    push(mk(32'h2100, 8'd1, 3'd1, 1'b1), 4'd7);
    tick();
    repeat (6) tick();
    aw_rdy_pct = 100;
    tick();
    check("wr_cnt_hs", wr_outstanding, 1);
    repeat (3) tick();

    // 4KB boundary: ends exactly at 0x0FFF is legal, one past crosses; oversize beat drops.
    push(mk(32'h0FF0, 8'd3, 3'd2, 1'b0), 4'd1);
    push(mk(32'h0FF8, 8'd3, 3'd2, 1'b0), 4'd3);
    push(mk(32'h3000, 8'd0, 3'd3, 1'b1), 4'd9);
    repeat (8) tick();

    // Credit limit: drain, queue 5 reads, release one credit.
    while (m_rd > 0) cpl_pulse(1'b0);
    while (m_wr > 0) cpl_pulse(1'b1);
    for (int i = 0; i < 5; i++) push(mk(32'h4000 + 32'(i) * 32'h100, 8'd0, 3'd2, 1'b0), 4'(10 + i));
    repeat (12) tick();
    check("credit_full", rd_outstanding, MAX);
    check("fifth_unpopped", pending_pop, 0);
    cpl_pulse(1'b0);
    tick();
    repeat (3) tick();

    // Handshake and read completion in the same cycle leave the count unchanged.
    cpl_pulse(1'b0); cpl_pulse(1'b0);
    push(mk(32'h5000, 8'd1, 3'd2, 1'b0), 4'd4);
    tick();
    check("simul_valid", ar_valid, 1);
    cpl_pulse(1'b0);
    check("simul_net", rd_outstanding, 2);

    // Underflow: write completion with no writes outstanding.
    while (m_wr > 0) cpl_pulse(1'b1);
    cpl_pulse(1'b1);
    check("uf_set", underflow_err, 1);
    check("uf_cnt0", wr_outstanding, 0);
    tick();

    // Random traffic.
    manual_cpl = 1'b0; cpl_pct = 30; ar_rdy_pct = 60; aw_rdy_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      if (dir_q.size() < 4 && $urandom_range(1) == 1) begin
        directory_entry_t e;
        e.addr = $urandom;
        if ($urandom_range(1) == 1) e.addr[11:0] = 12'(12'hF00 + $urandom_range(255));
        e.len      = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
        e.size     = 3'($urandom_range(3));
        e.burst    = 2'($urandom_range(2));
        e.is_write = 1'($urandom_range(1));
        push(e, 4'($urandom_range(15)));
      end
      tick();
    end

    // Reset while a read is being offered.
    ar_rdy_pct = 0; aw_rdy_pct = 100; cpl_pct = 50;
    push(mk(32'h6000, 8'd0, 3'd2, 1'b0), 4'd6);
    for (int w = 0; w < 200 && kind != 1; w++) tick();
    check("rst_mid_reached", ar_valid, 1);
    #2 presetn = 1'b0;
    #1;
    check("rst_mid_ar_valid", ar_valid, 0);
    check("rst_mid_rd_cnt", rd_outstanding, 0);
    check("rst_mid_wr_cnt", wr_outstanding, 0);
    check("rst_mid_uf", underflow_err, 0);
    dir_q.delete(); kind = 0; m_rd = 0; m_wr = 0; m_uf = 1'b0;
    pending_valid = 1'b0; cpl_valid = 1'b0; manual_cpl = 1'b1;
    @(negedge pclk);
    presetn = 1'b1;
    ar_rdy_pct = 100;
    push(mk(32'h7000, 8'd2, 3'd1, 1'b0), 4'd8);
    push(mk(32'h7FFC, 8'd1, 3'd2, 1'b1), 4'd11);
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
